// File: rtl/fp_to_int_converter.sv
// fp_to_int_converter: multi-cycle binary32 -> int32/uint32 converter; FP2INT_ASSERT_EN enables assertions
module fp_to_int_converter #(
  parameter int SHIFT_STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] fp_a,
  input  logic [2:0]  r_mode,
  input  logic        is_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] int_result,
  output logic        invalid,
  output logic        inexact
);
  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ROUND, DONE} state_t;
  localparam logic [4:0] STEP = SHIFT_STEP[4:0];
  state_t state, state_n;
  logic [31:0] a_q, mag, mag_n, res, sat_val;
  logic [2:0] rm_q;
  logic sg_q, sign, nan, ovf, g, s, inc, sat;
  logic nan_n, ovf_n, zero_n;
  logic [4:0] rs, rs_n, k;
  logic [7:0] exp;
  logic [23:0] mant;
  logic [3:0] sl;
  logic [32:0] ext, mask, r, neg, lim;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  // unpack: classify the captured operand and pre-align the mantissa
  always_comb begin
    exp = a_q[30:23];
    mant = {|exp, a_q[22:0]};
    nan_n = &exp & |a_q[22:0];
    ovf_n = !nan_n & (exp >= 8'd159);
    zero_n = exp == 8'd0 && a_q[22:0] == 23'd0;
    sl = 4'(exp - 8'd150);
    rs_n = (nan_n | ovf_n | zero_n | exp >= 8'd150) ? 5'd0 : exp <= 8'd125 ? 5'd25 : 5'(8'd150 - exp);
    mag_n = (nan_n | ovf_n | zero_n) ? 32'd0 : exp >= 8'd150 ? {8'd0, mant} << sl : {8'd0, mant};
  end
  // align/round: bounded right shift step and rounding/saturation of the aligned magnitude
  always_comb begin
    k = rs > STEP ? STEP : rs;
    ext = {mag, g};
    mask = (33'd1 << k) - 33'd1;
    inc = rm_q == 3'b001 ? 1'b0 : rm_q == 3'b010 ? sign & (g | s) : rm_q == 3'b011 ? !sign & (g | s) :
          rm_q == 3'b100 ? g : g & (s | mag[0]);
    r = {1'b0, mag} + {32'd0, inc};
    lim = sg_q ? {1'b0, sign, {31{!sign}}} : {1'b0, 32'hFFFF_FFFF};
    sat = nan | ovf | (r > lim) | (!sg_q & sign & |r);
    sat_val = (sign & !nan) ? (sg_q ? 32'h8000_0000 : 32'h0) : (sg_q ? 32'h7FFF_FFFF : 32'hFFFF_FFFF);
    neg = 33'd0 - r;
    res = sign ? neg[31:0] : r[31:0];
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // next-state: fixed single-cycle phases, ALIGN repeats until the shift is exhausted
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = in_valid ? UNPACK : IDLE;
      UNPACK:  state_n = ALIGN;
      ALIGN:   state_n = rs <= STEP ? ROUND : ALIGN;
      ROUND:   state_n = DONE;
      DONE:    state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  // datapath registers; results only change in ROUND so they hold through DONE
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {a_q, rm_q, sg_q, sign, nan, ovf, g, s, rs, mag} <= '0;
      {int_result, invalid, inexact} <= '0;
    end else begin
      if (in_valid && in_ready) {a_q, rm_q, sg_q} <= {fp_a, r_mode, is_signed};
      if (state == UNPACK) begin
        {sign, nan, ovf, g, s} <= {a_q[31], nan_n, ovf_n, 2'b00};
        rs <= rs_n;
        mag <= mag_n;
      end
      if (state == ALIGN) begin
        {mag, g} <= ext >> k;
        s <= s | |(ext & mask);
        rs <= rs - k;
      end
      if (state == ROUND) begin
        int_result <= sat ? sat_val : res;
        invalid <= sat;
        inexact <= !sat & (g | s);
      end
    end
`ifdef FP2INT_ASSERT_EN
  localparam int MAX_ALIGN = (25 + SHIFT_STEP - 1) / SHIFT_STEP;
  logic hold_q;
  logic [33:0] prev_q;
  logic [4:0] align_cnt;
  // protocol and bound checks on the registered outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hold_q <= 1'b0;
      prev_q <= '0;
      align_cnt <= '0;
    end else begin
      hold_q <= out_valid & !out_ready;
      prev_q <= {int_result, invalid, inexact};
      align_cnt <= state == ALIGN ? align_cnt + 5'd1 : 5'd0;
      if (hold_q) assert ({int_result, invalid, inexact} == prev_q);
      assert (!(invalid && inexact));
      assert (in_ready == (state == IDLE));
      assert (state != ALIGN || int'(align_cnt) < MAX_ALIGN);
    end
`endif
endmodule

// File: tb/tb_fp_to_int_converter.sv
// tb_fp_to_int_converter: randomized bench with an arithmetic reference model
module tb_fp_to_int_converter;
  logic clk = 0, rst_n = 0, in_valid = 0, in_ready, is_signed = 0, out_valid, out_ready = 0;
  logic invalid, inexact, hold = 0;
  logic [31:0] fp_a = 0, int_result;
  logic [2:0] r_mode = 0;
  int n_vec = 0, n_err = 0, cyc = 0;
  bit seen = 0;
  typedef struct { logic [33:0] exp; int due; } exp_t;
  exp_t q[$];

  fp_to_int_converter #(.SHIFT_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .fp_a(fp_a),
    .r_mode(r_mode), .is_signed(is_signed), .out_valid(out_valid), .out_ready(out_ready),
    .int_result(int_result), .invalid(invalid), .inexact(inexact));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // value = m * 2^(e-23); round the exact quotient/remainder, then range-check the signed value
  function automatic logic [33:0] model(logic [31:0] a, logic [2:0] rm, logic sg);
    int ex = int'(a[30:23]);
    int e = ex - 127;
    bit sgn = a[31];
    longint m = longint'(a[22:0]) + (ex != 0 ? 64'sd8388608 : 64'sd0);
    longint qv, rem, half, sv, lo, hi;
    bit up, nz;
    if (ex == 255 && a[22:0] != 0) return {sg ? 32'h7FFF_FFFF : 32'hFFFF_FFFF, 2'b10};
    if (ex == 255 || e >= 40) begin qv = 64'sd1 <<< 40; rem = 0; half = 1; end
    else if (e >= 23) begin qv = m <<< (e - 23); rem = 0; half = 1; end
    else if (23 - e > 60) begin qv = 0; rem = m; half = 64'sd1 <<< 60; end
    else begin
      qv = m >>> (23 - e);
      rem = m - (qv <<< (23 - e));
      half = 64'sd1 <<< (22 - e);
    end
    nz = rem != 0;
    case (rm)
      3'b001: up = 0;
      3'b010: up = sgn && nz;
      3'b011: up = !sgn && nz;
      3'b100: up = rem >= half;
      default: up = rem > half || (rem == half && qv[0]);
    endcase
    qv += longint'(up);
    sv = sgn ? -qv : qv;
    lo = sg ? -(64'sd1 <<< 31) : 0;
    hi = sg ? (64'sd1 <<< 31) - 1 : (64'sd1 <<< 32) - 1;
    if (sv < lo) return {sg ? 32'h8000_0000 : 32'h0, 2'b10};
    if (sv > hi) return {sg ? 32'h7FFF_FFFF : 32'hFFFF_FFFF, 2'b10};
    return {sv[31:0], 1'b0, nz};
  endfunction

  // ALIGN cycles: ceil(min(23-e,25)/4) for right shifts, otherwise one
  function automatic int n_align(logic [31:0] a);
    int ex = int'(a[30:23]);
    int e = ex - 127;
    int rs;
    if (ex == 255 || e >= 23 || (ex == 0 && a[22:0] == 0)) return 1;
    rs = (23 - e) < 25 ? 23 - e : 25;
    return (rs + 3) / 4;
  endfunction

  task automatic send(logic [31:0] a, logic [2:0] rm, logic sg);
    int w = 0;
    @(negedge clk);
    fp_a = a; r_mode = rm; is_signed = sg; in_valid = 1;
    while (!in_ready && w < 200) begin @(negedge clk); w++; end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 0;
      return;
    end
    q.push_back('{model(a, rm, sg), cyc + 3 + n_align(a)});
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic pin(string name, logic [31:0] a, logic [2:0] rm, logic sg, logic [33:0] req);
    chk(name, 64'(model(a, rm, sg)), 64'(req));
    send(a, rm, sg);
  endtask

  task automatic drain();
    int w = 0;
    while (q.size() != 0 && w < 2000) begin @(negedge clk); w++; end
    if (q.size() != 0) begin chk("drain_timeout", 64'(q.size()), 0); q.delete(); end
  endtask

  initial forever begin
    @(posedge clk);
    #1 out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // compare process: every output-valid cycle against the queued model result
  always @(negedge clk) if (rst_n && out_valid) begin
    if (q.size() == 0) chk("spurious_out_valid", 1, 0);
    else begin
      chk("result", {int_result, invalid, inexact}, q[0].exp);
      chk("in_ready_busy", in_ready, 0);
      if (!seen) chk("latency", cyc, q[0].due);
      seen = 1;
      if (out_ready) begin void'(q.pop_front()); seen = 0; end
    end
  end

  initial begin
    logic [31:0] a;
    int w;
    #23;
    chk("reset_state", {in_ready, out_valid, int_result, invalid, inexact}, {1'b1, 1'b0, 32'h0, 2'b00});
    @(negedge clk) rst_n = 1;
    chk("n_align_2p5", n_align(32'h4020_0000), 6);
    chk("n_align_0p25", n_align(32'h3E80_0000), 7);
    pin("2p5_rne", 32'h4020_0000, 3'b000, 1, {32'd2, 2'b01});
    pin("2p5_rmm", 32'h4020_0000, 3'b100, 1, {32'd3, 2'b01});
    pin("2p5_rup", 32'h4020_0000, 3'b011, 1, {32'd3, 2'b01});
    pin("2p5_rdn", 32'h4020_0000, 3'b010, 1, {32'd2, 2'b01});
    pin("2p5_rtz", 32'h4020_0000, 3'b001, 1, {32'd2, 2'b01});
    pin("m2p5_rdn", 32'hC020_0000, 3'b010, 1, {32'hFFFF_FFFD, 2'b01});
    pin("m2p5_rtz", 32'hC020_0000, 3'b001, 1, {32'hFFFF_FFFE, 2'b01});
    pin("2e31_s", 32'h4F00_0000, 3'b000, 1, {32'h7FFF_FFFF, 2'b10});
    pin("2e31_u", 32'h4F00_0000, 3'b000, 0, {32'h8000_0000, 2'b00});
    pin("m2e31_s", 32'hCF00_0000, 3'b000, 1, {32'h8000_0000, 2'b00});
    pin("nan_s", 32'h7FC0_0000, 3'b000, 1, {32'h7FFF_FFFF, 2'b10});
    pin("m1_u", 32'hBF80_0000, 3'b000, 0, {32'h0, 2'b10});
    pin("m0p25_u_rtz", 32'hBE80_0000, 3'b001, 0, {32'h0, 2'b01});
    pin("0p25_rtz", 32'h3E80_0000, 3'b001, 1, {32'h0, 2'b01});
    pin("0p25_rup", 32'h3E80_0000, 3'b011, 1, {32'h1, 2'b01});
    pin("neg_zero", 32'h8000_0000, 3'b000, 0, {32'h0, 2'b00});
    pin("rsvd_mode_rne", 32'h4060_0000, 3'b111, 1, {32'd4, 2'b01});
    drain();
    // back-pressure: result must hold while out_ready stays low
    hold = 1;
    send(32'h40A0_0000, 3'b000, 1);
    w = 0;
    while (!out_valid && w < 100) begin @(negedge clk); w++; end
    chk("hold_wait", out_valid, 1);
    repeat (5) begin @(negedge clk); chk("hold_valid", out_valid, 1); end
    hold = 0;
    drain();
    // asynchronous reset in the middle of ALIGN
    send(32'h3E80_0000, 3'b011, 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    #1 chk("mid_reset", {in_ready, out_valid, int_result, invalid, inexact}, {1'b1, 1'b0, 32'h0, 2'b00});
    q.delete();
    seen = 0;
    @(negedge clk) rst_n = 1;
    pin("after_reset", 32'h4020_0000, 3'b100, 0, {32'd3, 2'b01});
    drain();
    repeat (400) begin
      case ($urandom_range(0, 9))
        0: a[30:23] = 8'd0;
        1: a[30:23] = 8'd255;
        default: a[30:23] = 8'($urandom_range(110, 160));
      endcase
      a[22:0] = 23'($urandom);
      if ($urandom_range(0, 1) == 1) a[22:0] = a[22:0] & 23'h7F_F000;
      a[31] = 1'($urandom);
      send(a, 3'($urandom_range(0, 7)), 1'($urandom));
    end
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
